// File: rtl/riscv_lsu_if.sv
// Request/response bus between the load/store unit (master) and the cache controller (slave).
interface riscv_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                m_req;
    logic                m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [XLEN-1:0]     m_wdata;
    logic [XLEN/8-1:0]   m_be;
    logic                m_ready;
    logic                m_rvalid;
    logic [XLEN-1:0]     m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core load/store levels into a cache request/response handshake,
// steering store lanes, extending load data, rejecting misaligned accesses and aborting stuck ones.
module riscv_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   w_data,
    output logic [XLEN-1:0]   r_data,
    output logic              stall,
    output logic              misalign,
    output logic              timeout,
    riscv_lsu_if.master       bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               m_req_r;
    logic               m_we_r;
    logic [ADDR_W-1:0]  m_addr_r;
    logic [XLEN-1:0]    m_wdata_r;
    logic [BYTES-1:0]   m_be_r;
    logic [2:0]         f3_r;
    logic [OFF_W-1:0]   off_r;
    logic [XLEN-1:0]    r_data_r;
    logic               misalign_r;
    logic               timeout_r;

    logic               access_s;
    logic               we_s;
    logic [OFF_W-1:0]   off_s;
    logic               illegal_s;
    logic [BYTES-1:0]   be_s;
    logic [XLEN-1:0]    wdata_s;
    logic               expire_s;
    logic               stall_s;
    logic               accept_s;
    logic               reject_s;
    logic               capture_s;
    logic               abort_s;

    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0]  word,
        input logic [OFF_W-1:0] off,
        input logic [2:0]       f3
    );
        logic [XLEN-1:0] lane;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = XLEN'($signed(lane[7:0]));
            3'b001:  load_extend = XLEN'($signed(lane[15:0]));
            3'b010:  load_extend = XLEN'($signed(lane[31:0]));
            3'b100:  load_extend = XLEN'(lane[7:0]);
            3'b101:  load_extend = XLEN'(lane[15:0]);
            3'b110:  load_extend = XLEN'(lane[31:0]);
            default: load_extend = lane;
        endcase
    endfunction

    assign access_s = mem_read | mem_write;
    assign we_s     = mem_write & ~mem_read;
    assign off_s    = addr[OFF_W-1:0];
    assign expire_s = (TIMEOUT > 0) && (cnt_r == CNT_W'(TIMEOUT - 1));

    // Access legality: funct3 not available at this XLEN counts as misaligned
    always_comb begin
        illegal_s = 1'b0;
        case (funct3)
            3'b000:  illegal_s = 1'b0;
            3'b001:  illegal_s = addr[0];
            3'b010:  illegal_s = (addr[1:0] != 2'b00);
            3'b011:  illegal_s = (XLEN != 64) || (addr[2:0] != 3'b000);
            3'b100:  illegal_s = we_s;
            3'b101:  illegal_s = we_s || addr[0];
            3'b110:  illegal_s = we_s || (XLEN != 64) || (addr[1:0] != 2'b00);
            default: illegal_s = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_s    = '0;
        wdata_s = '0;
        case (funct3[1:0])
            2'b00: begin
                be_s    = BYTES'(1'b1) << off_s;
                wdata_s = {BYTES{w_data[7:0]}};
            end
            2'b01: begin
                be_s    = BYTES'(2'b11) << off_s;
                wdata_s = {(BYTES/2){w_data[15:0]}};
            end
            2'b10: begin
                be_s    = BYTES'(4'hF) << off_s;
                wdata_s = {(BYTES/4){w_data[31:0]}};
            end
            default: begin
                be_s    = '1;
                wdata_s = w_data;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; a completing handshake beats an expiring timeout
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s && !illegal_s) next_s = ST_REQ;
                else                        next_s = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.m_ready && (m_we_r || bus.m_rvalid)) next_s = ST_DONE;
                else if (expire_s)                           next_s = ST_DONE;
                else if (bus.m_ready)                        next_s = ST_WAIT;
                else                                         next_s = ST_REQ;
            end
            ST_WAIT: begin
                if (bus.m_rvalid || expire_s) next_s = ST_DONE;
                else                          next_s = ST_WAIT;
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Per-state control: stall, request latch, data capture and abort decisions
    always_comb begin
        stall_s   = 1'b0;
        accept_s  = 1'b0;
        reject_s  = 1'b0;
        capture_s = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s  = access_s && !illegal_s;
                accept_s = access_s && !illegal_s;
                reject_s = access_s && illegal_s;
            end
            ST_REQ: begin
                stall_s   = 1'b1;
                capture_s = bus.m_ready && !m_we_r && bus.m_rvalid;
                abort_s   = expire_s && !(bus.m_ready && (m_we_r || bus.m_rvalid));
            end
            ST_WAIT: begin
                stall_s   = 1'b1;
                capture_s = bus.m_rvalid;
                abort_s   = expire_s && !bus.m_rvalid;
            end
            ST_DONE: begin
                stall_s = 1'b0;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Cycle counter for REQ/WAIT, cleared while waiting in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            cnt_r <= '0;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Request fields, frozen from acceptance until the next accepted access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            m_be_r    <= '0;
            f3_r      <= 3'b000;
            off_r     <= '0;
        end else begin
            m_req_r <= (next_s == ST_REQ);
            if (accept_s) begin
                m_we_r    <= we_s;
                m_addr_r  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                m_wdata_r <= wdata_s;
                m_be_r    <= be_s;
                f3_r      <= funct3;
                off_r     <= off_s;
            end
        end
    end

    // Load result and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_r   <= '0;
            misalign_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            misalign_r <= reject_s;
            timeout_r  <= abort_s;
            if (capture_s) begin
                r_data_r <= load_extend(bus.m_rdata, off_r, f3_r);
            end else if (abort_s || reject_s) begin
                r_data_r <= '0;
            end
        end
    end

    assign stall       = reset & stall_s;
    assign r_data      = r_data_r;
    assign misalign    = misalign_r;
    assign timeout     = timeout_r;
    assign bus.m_req   = m_req_r;
    assign bus.m_we    = m_we_r;
    assign bus.m_addr  = m_addr_r;
    assign bus.m_wdata = m_wdata_r;
    assign bus.m_be    = m_be_r;
endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu (XLEN=32, TIMEOUT=4) against a
// transaction-level timeline model, plus directed scenarios with literal expectations.
module tb_riscv_lsu;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3    = 3'b000;
    logic [31:0] addr      = 32'h0;
    logic [31:0] w_data    = 32'h0;
    logic [31:0] r_data;
    logic        stall;
    logic        misalign;
    logic        timeout;

    riscv_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    riscv_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .w_data(w_data), .r_data(r_data),
        .stall(stall), .misalign(misalign), .timeout(timeout), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // expected per-cycle outputs, written by the driver, read by the compare process
    bit          exp_on = 1'b0;
    bit          exp_stall, exp_req, exp_mis, exp_to, exp_we;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] cur_rdata = 32'h0;

    int          req_cycles, stall_cycles, mis_cycles, to_cycles;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit legal_acc(input bit is_st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (is_st && f3 > 3'd2) return 1'b0;
        if (!is_st && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[2:0]) % size) == 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [31:0] a, input logic [2:0] f3);
        longint v, bits;
        bits = (f3[1:0] == 2'd0) ? 64'sd8 : (f3[1:0] == 2'd1) ? 64'sd16 : 64'sd32;
        v = longint'(word >> (8 * int'(a[1:0]))) & ((longint'(1) << bits) - 1);
        if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    task automatic clear_counters();
        req_cycles = 0; stall_cycles = 0; mis_cycles = 0; to_cycles = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus.m_ready  = 1'($urandom_range(0, 1));
        bus.m_rvalid = 1'($urandom_range(0, 1));
        bus.m_rdata  = $urandom;
    endtask

    task automatic idle_cycle(input bit mis);
        mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'($urandom); addr = $urandom;
        noise();
        exp_on = 1'b1; exp_stall = 1'b0; exp_req = 1'b0; exp_mis = mis; exp_to = 1'b0;
        exp_rdata = cur_rdata;
        step();
    endtask

    // One core instruction: rdy = REQ cycles before m_ready, lat = cycles from m_ready to m_rvalid
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int rdy, input int lat, input logic [31:0] word);
        bit is_st, legal, to;
        int busy, n, nreq, off;
        is_st = wr && !rd;
        legal = legal_acc(is_st, f3, a);
        off   = int'(a[1:0]);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; w_data = wd;
        noise();
        exp_on = 1'b1; exp_stall = legal; exp_req = 1'b0; exp_mis = 1'b0; exp_to = 1'b0;
        exp_rdata = cur_rdata;
        exp_we    = is_st;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_be    = 4'((f3 == 3'd0) ? (1 << off) : (f3 == 3'd1) ? (3 << off) : 15);
        exp_wdata = (f3 == 3'd0) ? ({24'h0, wd[7:0]} * 32'h0101_0101) :
                    (f3 == 3'd1) ? ({16'h0, wd[15:0]} * 32'h0001_0001) : wd;
        step();
        if (!legal) begin
            cur_rdata = 32'h0;
            idle_cycle(1'b1);
            return;
        end
        busy = is_st ? rdy + 1 : rdy + 1 + lat;
        to   = busy > TIMEOUT;
        n    = to ? TIMEOUT : busy;
        nreq = (rdy + 1 < n) ? rdy + 1 : n;
        for (int i = 1; i <= n; i++) begin
            bus.m_ready  = (i == rdy + 1);
            bus.m_rvalid = !is_st && (i == rdy + 1 + lat);
            bus.m_rdata  = bus.m_rvalid ? word : $urandom;
            exp_stall = 1'b1; exp_req = (i <= nreq);
            step();
        end
        noise();
        if (to)          cur_rdata = 32'h0;
        else if (!is_st) cur_rdata = load_val(word, a, f3);
        exp_stall = 1'b0; exp_req = 1'b0; exp_to = to; exp_rdata = cur_rdata;
        step();
    endtask

    // Compare process: DUT against the model every cycle, plus observation counters
    always @(negedge clk) begin
        if (bus.m_req) begin
            req_cycles++;
            seen_addr = bus.m_addr; seen_wdata = bus.m_wdata; seen_be = bus.m_be; seen_we = bus.m_we;
        end
        if (stall)    stall_cycles++;
        if (misalign) mis_cycles++;
        if (timeout)  to_cycles++;
        if (exp_on) begin
            chk("stall",    32'(stall),    32'(exp_stall));
            chk("m_req",    32'(bus.m_req), 32'(exp_req));
            chk("misalign", 32'(misalign), 32'(exp_mis));
            chk("timeout",  32'(timeout),  32'(exp_to));
            chk("r_data",   r_data,        exp_rdata);
            if (exp_req) begin
                chk("m_we",   32'(bus.m_we), 32'(exp_we));
                chk("m_addr", bus.m_addr,    exp_addr);
                if (exp_we) begin
                    chk("m_be",    32'(bus.m_be), 32'(exp_be));
                    chk("m_wdata", bus.m_wdata,   exp_wdata);
                end
            end
        end
    end

    initial begin
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
        mem_read = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r_data", r_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_m_req", 32'(bus.m_req), 32'h0);
        chk("rst_m_we", 32'(bus.m_we), 32'h0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);
        chk("rst_m_be", 32'(bus.m_be), 32'h0);
        mem_read = 1'b0;
        reset = 1'b1;
        step();

        clear_counters();
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        chk("sw_req_cycles", 32'(req_cycles), 32'd1);
        chk("sw_stall_cycles", 32'(stall_cycles), 32'd2);
        chk("sw_be", 32'(seen_be), 32'hF);
        chk("sw_addr", seen_addr, 32'h100);
        chk("sw_we", 32'(seen_we), 32'd1);
        chk("sw_wdata", seen_wdata, 32'hDEADBEEF);

        clear_counters();
        do_access(1'b1, 1'b0, 3'b000, 32'h103, $urandom, 0, 2, 32'h80FF0000);
        chk("lb_r_data", r_data, 32'hFFFFFF80);
        chk("lb_stall_cycles", 32'(stall_cycles), 32'd4);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, $urandom, 0, 2, 32'h80FF0000);
        chk("lbu_r_data", r_data, 32'h00000080);

        do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 0, 0, 32'h0);
        chk("sh_be", 32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wdata, 32'h12341234);
        chk("sh_addr", seen_addr, 32'h200);

        clear_counters();
        do_access(1'b1, 1'b0, 3'b010, 32'h101, $urandom, 0, 0, 32'h55AA55AA);
        chk("mis_pulses", 32'(mis_cycles), 32'd1);
        chk("mis_req_cycles", 32'(req_cycles), 32'd0);
        chk("mis_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("mis_r_data", r_data, 32'h0);

        do_access(1'b1, 1'b0, 3'b010, 32'h40, $urandom, 1, 0, 32'hCAFEF00D);
        chk("lw_r_data", r_data, 32'hCAFEF00D);
        clear_counters();
        do_access(1'b1, 1'b0, 3'b010, 32'h44, $urandom, 50, 0, 32'h0);
        chk("to_req_cycles", 32'(req_cycles), 32'd4);
        chk("to_pulses", 32'(to_cycles), 32'd1);
        chk("to_r_data", r_data, 32'h0);
        chk("to_stall_cycles", 32'(stall_cycles), 32'd5);

        // reset in the middle of an outstanding request, then a stray m_rvalid
        exp_on = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h80;
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b0;
        step();
        chk("rst_mid_req_before", 32'(bus.m_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_req_drop", 32'(bus.m_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        step();
        mem_read = 1'b0; reset = 1'b1;
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFFFFFFFF;
        step();
        bus.m_rvalid = 1'b0;
        chk("late_rvalid_r_data", r_data, 32'h0);
        chk("late_rvalid_stall", 32'(stall), 32'd0);
        cur_rdata = 32'h0;
        do_access(1'b1, 1'b0, 3'b010, 32'h40, $urandom, 0, 1, 32'h12345678);
        chk("post_rst_lw", r_data, 32'h12345678);

        for (int t = 0; t < 400; t++) begin
            int          sel;
            logic [31:0] a;
            logic [2:0]  f3;
            sel = $urandom_range(0, 3);
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            f3  = (sel == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            do_access(sel != 0, sel == 0 || sel == 2, f3, a, $urandom,
                      $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycle(1'b0);
        end

        exp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
